tl_bank_arbiter: RTL and testbench
==================================

// Module: tl_bank_arbiter
// PURPOSE
//  Shares one downstream TL-UL bank port between two upstream requesters. Arbitrates the A channel
//  round-robin per message, locking the grant for multi-beat writes. Tags out source MSB with port index.
//  Routes D responses back by that bit. Throttles each port to MAX_INFLIGHT outstanding requests.
//  Sits in front of a bank binder / bank slave, behind two crossbar-side master ports.
// PARAMETERS
//  SRC_BITS      6  upstream source width; downstream source is SRC_BITS+1
//  MAX_INFLIGHT  4  max outstanding requests per port (A first beat accepted, D last beat not yet accepted)
//  MAX_LG_SIZE   6  largest legal size (64 B = 8 beats of 64-bit data)
// PORTS
//  clock                                  in   1   single clock, all state on rising edge
//  reset                                  in   1   synchronous, active-high
//  in{0,1}_a_valid / in{0,1}_a_ready      in/out 1 per-port A handshake
//  in{0,1}_a_bits_opcode, _size           in   3   TL opcode, lg2 bytes
//  in{0,1}_a_bits_source                  in   SRC_BITS
//  in{0,1}_a_bits_address/_mask/_data     in   32/8/64
//  in{0,1}_d_valid / in{0,1}_d_ready      out/in 1 per-port D handshake
//  in{0,1}_d_bits_opcode, _size           out  3
//  in{0,1}_d_bits_source                  out  SRC_BITS  out_d source[SRC_BITS-1:0]
//  in{0,1}_d_bits_denied/_data/_corrupt   out  1/64/1
//  out_a_valid / out_a_ready              out/in 1
//  out_a_bits_opcode/_size                out  3
//  out_a_bits_source                      out  SRC_BITS+1  {port, in source}
//  out_a_bits_address/_mask/_data         out  32/8/64
//  out_d_valid / out_d_ready              in/out 1
//  out_d_bits_opcode/_size/_source        in   3/3/SRC_BITS+1
//  out_d_bits_denied/_data/_corrupt       in   1/64/1
// BEHAVIOUR
//  - Beats: A has data iff opcode 0/1 (PutFull/PutPartial); D has data iff opcode 1 (AccessAckData).
//    beats = (hasData && size>3) ? 1<<(size-3) : 1.
//  - Reset: state IDLE, rr=0, grant=0, a_cnt=0, d_cnt=0, inflight0=inflight1=0.
//    All valid/ready outputs 0 while reset is high.
//  - eligible_i = in_i_a_valid && inflight_i < MAX_INFLIGHT.
//  - State IDLE: grant = both eligible ? rr : the eligible port. Grant is combinational, zero latency.
//    out_a = granted port's bits, with source {port, src}; out_a_valid = granted eligible.
//    granted in_a_ready = out_a_ready; the other port's ready = 0.
//    - Valid && !ready: go to STALL; register grant.
//    - Fire with beats>1: go to BURST; a_cnt = beats-1.
//    - On any first-beat fire: rr <= ~grant.
//  - State STALL: grant frozen; out_a bits must stay stable (TL rule). On fire: go to BURST if beats>1, else IDLE.
//    rr update is the same as in IDLE.
//  - State BURST: only the locked port is connected; ineligibility is ignored mid-burst.
//    Each fire: a_cnt--. Fire with a_cnt==1: go to IDLE.
//  - inflight_i: +1 on port i first A beat fire; -1 on last D beat fire to port i; both at once = no change.
//  - D path, stateless routing: j = out_d source[SRC_BITS]. in_j_d_valid = out_d_valid.
//    out_d_ready = in_j_d_ready. The other port's d_valid = 0.
//  - D last beat: d_cnt==0 ? beats==1 : d_cnt==1. On D fire: d_cnt = (d_cnt==0) ? beats-1 : d_cnt-1.
//  - Reset mid-operation: abandons any partial burst and all counts. Downstream must be reset together.
//  - size > MAX_LG_SIZE is illegal: simulation assertion, RTL behaviour undefined.
// TESTING
//  1. After reset, both ports Get (size 3) in one cycle, out_a_ready=1.
//     -> cycle 0 grants port0 (source 0x0A -> 0x0A); cycle 1 grants port1 (0x0A -> 0x4A); alternation continues.
//  2. Port0 PutFull size 6 while port1 holds a Get.
//     -> 8 contiguous port0 beats; port1 accepted on the cycle after the 8th beat.
//  3. Port1 granted, out_a_ready=0 for 5 cycles, port0 valid throughout.
//     -> out_a bits and grant stay port1, in0_a_ready=0; port1 fires on cycle 6.
//  4. Port0 issues 4 Gets, no D. -> 5th Get sees in0_a_ready=0 although out_a_ready=1.
//     Return AccessAckData size 3, source 0x05 -> in0_d_valid=1, inflight0=3; 5th Get fires next cycle.
//  5. out_d opcode 1, size 5, source 0x45. -> 4 beats on in1_d, source 0x05.
//     in1_d_ready=0 forces out_d_ready=0; inflight1 drops only on the 4th beat fire.
//  6. reset asserted after beat 3 of an 8-beat PutFull.
//     -> next cycle: IDLE, a_cnt=0, inflight=0, out_a_valid=0, all readys 0 while reset is held.

Source files
------------

// File: rtl/tl_bank_arbiter_if.sv
// tl_bank_arbiter_if: one TL-UL link (A request, D response).
// SW is the source-id width of this particular link.
interface tl_bank_arbiter_if #(
  parameter int SW = 6
);
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_bits_opcode;
  logic [2:0]    a_bits_size;
  logic [SW-1:0] a_bits_source;
  logic [31:0]   a_bits_address;
  logic [7:0]    a_bits_mask;
  logic [63:0]   a_bits_data;

  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_bits_opcode;
  logic [2:0]    d_bits_size;
  logic [SW-1:0] d_bits_source;
  logic          d_bits_denied;
  logic [63:0]   d_bits_data;
  logic          d_bits_corrupt;

  modport master (
    output a_valid, a_bits_opcode, a_bits_size,
    output a_bits_source, a_bits_address,
    output a_bits_mask, a_bits_data, d_ready,
    input  a_ready, d_valid, d_bits_opcode,
    input  d_bits_size, d_bits_source,
    input  d_bits_denied, d_bits_data, d_bits_corrupt
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_size,
    input  a_bits_source, a_bits_address,
    input  a_bits_mask, a_bits_data, d_ready,
    output a_ready, d_valid, d_bits_opcode,
    output d_bits_size, d_bits_source,
    output d_bits_denied, d_bits_data, d_bits_corrupt
  );
endinterface

// File: rtl/tl_bank_arbiter.sv
// tl_bank_arbiter: two TL-UL masters share one bank port.
// Round-robin per message, burst lock, per-port inflight throttle.
module tl_bank_arbiter #(
  parameter int SRC_BITS     = 6,
  parameter int MAX_INFLIGHT = 4,
  parameter int MAX_LG_SIZE  = 6
) (
  input  logic clock,
  input  logic reset,
  tl_bank_arbiter_if.slave  in0,
  tl_bank_arbiter_if.slave  in1,
  tl_bank_arbiter_if.master out
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAXI = IW'(MAX_INFLIGHT);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    BURST
  } state_t;

  state_t        state;
  logic          rr;
  logic          grant;
  logic [3:0]    a_cnt;
  logic [3:0]    d_cnt;
  logic [IW-1:0] inflight0;
  logic [IW-1:0] inflight1;

  logic       elig0, elig1;
  logic       gsel;
  logic       sel_valid;
  logic       sel_ok;
  logic       a_fire;
  logic       first_fire;
  logic [3:0] a_nb;
  logic       dj;
  logic       d_fire;
  logic [3:0] d_nb;
  logic       d_last;
  logic       inc0, inc1, dec0, dec1;

  function automatic logic [3:0] a_beats(
    input logic [2:0] op,
    input logic [2:0] sz
  );
    if ((op == 3'd0 || op == 3'd1) && sz > 3'd3)
      return 4'd1 << (sz - 3'd3);
    return 4'd1;
  endfunction

  function automatic logic [3:0] d_beats(
    input logic [2:0] op,
    input logic [2:0] sz
  );
    if (op == 3'd1 && sz > 3'd3)
      return 4'd1 << (sz - 3'd3);
    return 4'd1;
  endfunction

  assign elig0 = in0.a_valid && (inflight0 < MAXI);
  assign elig1 = in1.a_valid && (inflight1 < MAXI);

  // Only IDLE arbitrates; STALL and BURST hold the registered grant.
  always_comb begin
    gsel      = grant;
    sel_valid = grant ? in1.a_valid : in0.a_valid;
    sel_ok    = 1'b1;
    if (state == IDLE) begin
      gsel      = (elig0 && elig1) ? rr : elig1;
      sel_valid = gsel ? elig1 : elig0;
      sel_ok    = sel_valid;
    end
  end

  assign out.a_valid        = !reset && sel_valid;
  assign out.a_bits_opcode  = gsel ? in1.a_bits_opcode  : in0.a_bits_opcode;
  assign out.a_bits_size    = gsel ? in1.a_bits_size    : in0.a_bits_size;
  assign out.a_bits_address = gsel ? in1.a_bits_address : in0.a_bits_address;
  assign out.a_bits_mask    = gsel ? in1.a_bits_mask    : in0.a_bits_mask;
  assign out.a_bits_data    = gsel ? in1.a_bits_data    : in0.a_bits_data;
  assign out.a_bits_source  =
    {gsel, gsel ? in1.a_bits_source : in0.a_bits_source};

  assign in0.a_ready = !reset && !gsel && sel_ok && out.a_ready;
  assign in1.a_ready = !reset &&  gsel && sel_ok && out.a_ready;

  assign a_fire     = out.a_valid && out.a_ready;
  assign first_fire = a_fire && (state != BURST);
  assign a_nb       = a_beats(out.a_bits_opcode, out.a_bits_size);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      grant <= 1'b0;
      a_cnt <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (out.a_valid) begin
            grant <= gsel;
            if (!out.a_ready) begin
              state <= STALL;
            end else if (a_nb > 4'd1) begin
              state <= BURST;
              a_cnt <= a_nb - 4'd1;
            end
          end
        end
        STALL: begin
          if (a_fire) begin
            state <= (a_nb > 4'd1) ? BURST : IDLE;
            a_cnt <= a_nb - 4'd1;
          end
        end
        BURST: begin
          if (a_fire) begin
            a_cnt <= a_cnt - 4'd1;
            if (a_cnt == 4'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (first_fire) rr <= ~gsel;
    end
  end

  // D routing is stateless: the tag bit picks the port.
  assign dj = out.d_bits_source[SRC_BITS];

  assign in0.d_valid = !reset && out.d_valid && !dj;
  assign in1.d_valid = !reset && out.d_valid &&  dj;
  assign out.d_ready = !reset && (dj ? in1.d_ready : in0.d_ready);

  assign in0.d_bits_opcode  = out.d_bits_opcode;
  assign in0.d_bits_size    = out.d_bits_size;
  assign in0.d_bits_source  = out.d_bits_source[SRC_BITS-1:0];
  assign in0.d_bits_denied  = out.d_bits_denied;
  assign in0.d_bits_data    = out.d_bits_data;
  assign in0.d_bits_corrupt = out.d_bits_corrupt;

  assign in1.d_bits_opcode  = out.d_bits_opcode;
  assign in1.d_bits_size    = out.d_bits_size;
  assign in1.d_bits_source  = out.d_bits_source[SRC_BITS-1:0];
  assign in1.d_bits_denied  = out.d_bits_denied;
  assign in1.d_bits_data    = out.d_bits_data;
  assign in1.d_bits_corrupt = out.d_bits_corrupt;

  assign d_fire = out.d_valid && out.d_ready;
  assign d_nb   = d_beats(out.d_bits_opcode, out.d_bits_size);
  assign d_last = (d_cnt == 4'd0) ? (d_nb == 4'd1) : (d_cnt == 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      d_cnt <= 4'd0;
    end else if (d_fire) begin
      d_cnt <= (d_cnt == 4'd0) ? d_nb - 4'd1 : d_cnt - 4'd1;
    end
  end

  assign inc0 = first_fire && !gsel;
  assign inc1 = first_fire &&  gsel;
  assign dec0 = d_fire && d_last && !dj;
  assign dec1 = d_fire && d_last &&  dj;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight0 <= '0;
      inflight1 <= '0;
    end else begin
      if (inc0 && !dec0) inflight0 <= inflight0 + ONE;
      if (dec0 && !inc0) inflight0 <= inflight0 - ONE;
      if (inc1 && !dec1) inflight1 <= inflight1 + ONE;
      if (dec1 && !inc1) inflight1 <= inflight1 - ONE;
    end
  end

  a0_size_legal: assert property (
    @(posedge clock) disable iff (reset)
    in0.a_valid |-> in0.a_bits_size <= 3'(MAX_LG_SIZE)
  );
  a1_size_legal: assert property (
    @(posedge clock) disable iff (reset)
    in1.a_valid |-> in1.a_bits_size <= 3'(MAX_LG_SIZE)
  );

endmodule

// File: tb/tb_tl_bank_arbiter.sv
// tb_tl_bank_arbiter: table-driven A-channel vectors plus
// hand sequences for bursts, throttling, D routing and reset.
module tb_tl_bank_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tl_bank_arbiter_if #(.SW(6)) in0_if ();
  tl_bank_arbiter_if #(.SW(6)) in1_if ();
  tl_bank_arbiter_if #(.SW(7)) out_if ();

  tl_bank_arbiter #(
    .SRC_BITS    (6),
    .MAX_INFLIGHT(4),
    .MAX_LG_SIZE (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in0  (in0_if),
    .in1  (in1_if),
    .out  (out_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       a0v;
    logic [5:0] a0src;
    logic       a1v;
    logic [5:0] a1src;
    logic       oar;
    logic       eov;
    logic [6:0] esrc;
    logic       er0;
    logic       er1;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic a0v, input logic [5:0] a0src,
    input logic a1v, input logic [5:0] a1src,
    input logic oar, input logic eov,
    input logic [6:0] esrc,
    input logic er0, input logic er1
  );
    vec_t v;
    v.a0v = a0v; v.a0src = a0src;
    v.a1v = a1v; v.a1src = a1src;
    v.oar = oar; v.eov = eov; v.esrc = esrc;
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv_a(
    input int p, input logic v,
    input logic [2:0] op, input logic [2:0] sz,
    input logic [5:0] src
  );
    if (p == 0) begin
      in0_if.a_valid        = v;
      in0_if.a_bits_opcode  = op;
      in0_if.a_bits_size    = sz;
      in0_if.a_bits_source  = src;
      in0_if.a_bits_address = {26'h0, src};
      in0_if.a_bits_mask    = 8'hff;
      in0_if.a_bits_data    = {58'h0, src};
    end else begin
      in1_if.a_valid        = v;
      in1_if.a_bits_opcode  = op;
      in1_if.a_bits_size    = sz;
      in1_if.a_bits_source  = src;
      in1_if.a_bits_address = {26'h1, src};
      in1_if.a_bits_mask    = 8'hff;
      in1_if.a_bits_data    = {58'h1, src};
    end
  endtask

  task automatic drv_d(
    input logic v, input logic [2:0] op,
    input logic [2:0] sz, input logic [6:0] src
  );
    out_if.d_valid        = v;
    out_if.d_bits_opcode  = op;
    out_if.d_bits_size    = sz;
    out_if.d_bits_source  = src;
    out_if.d_bits_denied  = 1'b0;
    out_if.d_bits_data    = 64'hd00d;
    out_if.d_bits_corrupt = 1'b0;
  endtask

  task automatic idle_inputs();
    drv_a(0, 1'b0, 3'd4, 3'd3, 6'h00);
    drv_a(1, 1'b0, 3'd4, 3'd3, 6'h00);
    drv_d(1'b0, 3'd0, 3'd3, 7'h00);
    out_if.a_ready = 1'b0;
    in0_if.d_ready = 1'b0;
    in1_if.d_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;

    tbl[0]  = mk(1, 6'h0A, 1, 6'h0A, 1, 1, 7'h0A, 1, 0);
    tbl[1]  = mk(1, 6'h0A, 1, 6'h0A, 1, 1, 7'h4A, 0, 1);
    tbl[2]  = mk(1, 6'h0A, 1, 6'h0A, 1, 1, 7'h0A, 1, 0);
    tbl[3]  = mk(1, 6'h0A, 1, 6'h0A, 1, 1, 7'h4A, 0, 1);
    tbl[4]  = mk(1, 6'h22, 0, 6'h11, 1, 1, 7'h22, 1, 0);
    tbl[5]  = mk(1, 6'h22, 1, 6'h11, 0, 1, 7'h51, 0, 0);
    tbl[6]  = mk(1, 6'h22, 1, 6'h11, 0, 1, 7'h51, 0, 0);
    tbl[7]  = mk(1, 6'h22, 1, 6'h11, 0, 1, 7'h51, 0, 0);
    tbl[8]  = mk(1, 6'h22, 1, 6'h11, 0, 1, 7'h51, 0, 0);
    tbl[9]  = mk(1, 6'h22, 1, 6'h11, 0, 1, 7'h51, 0, 0);
    tbl[10] = mk(1, 6'h22, 1, 6'h11, 1, 1, 7'h51, 0, 1);
    tbl[11] = mk(1, 6'h22, 1, 6'h11, 1, 1, 7'h22, 1, 0);
    tbl[12] = mk(1, 6'h22, 1, 6'h11, 1, 1, 7'h51, 0, 1);
    tbl[13] = mk(1, 6'h22, 1, 6'h11, 1, 0, 7'h00, 0, 0);

    // Reset gating with every input asserted
    repeat (2) @(negedge clock);
    drv_a(0, 1'b1, 3'd4, 3'd3, 6'h0A);
    drv_a(1, 1'b1, 3'd4, 3'd3, 6'h0A);
    drv_d(1'b1, 3'd1, 3'd3, 7'h05);
    out_if.a_ready = 1'b1;
    in0_if.d_ready = 1'b1;
    in1_if.d_ready = 1'b1;
    #1;
    chk("rst out_a_valid", out_if.a_valid, 0);
    chk("rst in0_a_ready", in0_if.a_ready, 0);
    chk("rst in1_a_ready", in1_if.a_ready, 0);
    chk("rst out_d_ready", out_if.d_ready, 0);
    chk("rst in0_d_valid", in0_if.d_valid, 0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst a_cnt", dut.a_cnt, 0);
    chk("rst inflight0", dut.inflight0, 0);
    chk("rst inflight1", dut.inflight1, 0);
    chk("rst rr", dut.rr, 0);

    // Alternation, stall hold, inflight limit
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      drv_a(0, tbl[i].a0v, 3'd4, 3'd3, tbl[i].a0src);
      drv_a(1, tbl[i].a1v, 3'd4, 3'd3, tbl[i].a1src);
      out_if.a_ready = tbl[i].oar;
      #1;
      chk($sformatf("v%0d out_a_valid", i), out_if.a_valid, tbl[i].eov);
      if (tbl[i].eov)
        chk($sformatf("v%0d out_a_source", i),
            out_if.a_bits_source, tbl[i].esrc);
      chk($sformatf("v%0d in0_a_ready", i), in0_if.a_ready, tbl[i].er0);
      chk($sformatf("v%0d in1_a_ready", i), in1_if.a_ready, tbl[i].er1);
    end
    chk("tbl inflight0", dut.inflight0, 4);
    chk("tbl inflight1", dut.inflight1, 4);

    // Eight-beat PutFull locks port0, port1 waits
    do_reset();
    @(negedge clock);
    drv_a(0, 1'b1, 3'd0, 3'd6, 6'h01);
    drv_a(1, 1'b1, 3'd4, 3'd3, 6'h02);
    out_if.a_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("burst b%0d src", b), out_if.a_bits_source, 7'h01);
      chk($sformatf("burst b%0d r0", b), in0_if.a_ready, 1);
      chk($sformatf("burst b%0d r1", b), in1_if.a_ready, 0);
      if (b == 1) chk("burst a_cnt", dut.a_cnt, 7);
      @(negedge clock);
    end
    #1;
    chk("burst after src", out_if.a_bits_source, 7'h42);
    chk("burst after r1", in1_if.a_ready, 1);
    chk("burst after r0", in0_if.a_ready, 0);

    // Inflight throttle released by a D response
    do_reset();
    @(negedge clock);
    drv_a(0, 1'b1, 3'd4, 3'd3, 6'h05);
    out_if.a_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("thr get%0d r0", g), in0_if.a_ready, 1);
      @(negedge clock);
    end
    #1;
    chk("thr blocked r0", in0_if.a_ready, 0);
    chk("thr blocked valid", out_if.a_valid, 0);
    chk("thr inflight0 full", dut.inflight0, 4);
    drv_d(1'b1, 3'd1, 3'd3, 7'h05);
    in0_if.d_ready = 1'b1;
    #1;
    chk("thr in0_d_valid", in0_if.d_valid, 1);
    chk("thr in1_d_valid", in1_if.d_valid, 0);
    chk("thr in0_d_source", in0_if.d_bits_source, 6'h05);
    chk("thr out_d_ready", out_if.d_ready, 1);
    @(negedge clock);
    drv_d(1'b0, 3'd1, 3'd3, 7'h05);
    #1;
    chk("thr inflight0 drop", dut.inflight0, 3);
    chk("thr 5th r0", in0_if.a_ready, 1);
    @(negedge clock);
    drv_a(0, 1'b0, 3'd4, 3'd3, 6'h05);
    #1;
    chk("thr inflight0 refill", dut.inflight0, 4);

    // Four-beat AccessAckData routed to port1
    do_reset();
    @(negedge clock);
    drv_a(1, 1'b1, 3'd4, 3'd3, 6'h05);
    out_if.a_ready = 1'b1;
    #1;
    chk("dr a source", out_if.a_bits_source, 7'h45);
    @(negedge clock);
    drv_a(1, 1'b0, 3'd4, 3'd3, 6'h05);
    drv_d(1'b1, 3'd1, 3'd5, 7'h45);
    in1_if.d_ready = 1'b0;
    #1;
    chk("dr in1_d_valid", in1_if.d_valid, 1);
    chk("dr in0_d_valid", in0_if.d_valid, 0);
    chk("dr in1_d_source", in1_if.d_bits_source, 6'h05);
    chk("dr backpressure", out_if.d_ready, 0);
    chk("dr inflight1 held", dut.inflight1, 1);
    @(negedge clock);
    in1_if.d_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("dr beat%0d ready", b), out_if.d_ready, 1);
      chk($sformatf("dr beat%0d inflight1", b), dut.inflight1, 1);
      @(negedge clock);
    end
    drv_d(1'b0, 3'd1, 3'd5, 7'h45);
    #1;
    chk("dr inflight1 done", dut.inflight1, 0);
    chk("dr d_cnt done", dut.d_cnt, 0);

    // Reset in the middle of a burst
    do_reset();
    @(negedge clock);
    drv_a(0, 1'b1, 3'd0, 3'd6, 6'h01);
    out_if.a_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("mid a_cnt", dut.a_cnt, 5);
    reset = 1'b1;
    in1_if.d_ready = 1'b1;
    drv_d(1'b1, 3'd0, 3'd3, 7'h40);
    #1;
    chk("mid rst valid", out_if.a_valid, 0);
    chk("mid rst r0", in0_if.a_ready, 0);
    chk("mid rst r1", in1_if.a_ready, 0);
    chk("mid rst d_ready", out_if.d_ready, 0);
    chk("mid rst in1_d_valid", in1_if.d_valid, 0);
    @(negedge clock);
    #1;
    chk("mid rst a_cnt", dut.a_cnt, 0);
    chk("mid rst inflight0", dut.inflight0, 0);
    chk("mid rst held valid", out_if.a_valid, 0);
    drv_a(0, 1'b0, 3'd0, 3'd6, 6'h01);
    drv_a(1, 1'b1, 3'd4, 3'd3, 6'h03);
    drv_d(1'b0, 3'd0, 3'd3, 7'h00);
    reset = 1'b0;
    #1;
    chk("post rst valid", out_if.a_valid, 1);
    chk("post rst src", out_if.a_bits_source, 7'h43);
    chk("post rst r1", in1_if.a_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
